// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX stage register, the forward sources and the ALU.
// The slave modport is the stage itself. The master modport is whoever drives decode and observes EX.
interface id_ex_stage_if;
  logic        flush_i;
  logic        hold_i;
  logic        valid_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic [31:0] imm_i;
  logic [4:0]  shamt_i;
  logic [4:0]  write_addr_i;
  logic [3:0]  alu_operation_i;
  logic        alu_src_i;
  logic        reg_write_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        mem_to_reg_i;
  logic        ex_mem_reg_write_i;
  logic [4:0]  ex_mem_write_addr_i;
  logic [31:0] ex_mem_data_i;
  logic        mem_wb_reg_write_i;
  logic [4:0]  mem_wb_write_addr_i;
  logic [31:0] mem_wb_data_i;

  logic        stall_o;
  logic        valid_o;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [4:0]  shamt_o;
  logic [3:0]  alu_operation_o;
  logic [31:0] store_data_o;
  logic [4:0]  write_addr_o;
  logic        reg_write_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        mem_to_reg_o;

  modport slave (
    input  flush_i, hold_i, valid_i, rs_addr_i, rt_addr_i, rs_data_i, rt_data_i,
           imm_i, shamt_i, write_addr_i, alu_operation_i, alu_src_i,
           reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i,
           ex_mem_reg_write_i, ex_mem_write_addr_i, ex_mem_data_i,
           mem_wb_reg_write_i, mem_wb_write_addr_i, mem_wb_data_i,
    output stall_o, valid_o, a_o, b_o, shamt_o, alu_operation_o, store_data_o,
           write_addr_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o
  );

  modport master (
    output flush_i, hold_i, valid_i, rs_addr_i, rt_addr_i, rs_data_i, rt_data_i,
           imm_i, shamt_i, write_addr_i, alu_operation_i, alu_src_i,
           reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i,
           ex_mem_reg_write_i, ex_mem_write_addr_i, ex_mem_data_i,
           mem_wb_reg_write_i, mem_wb_write_addr_i, mem_wb_data_i,
    input  stall_o, valid_o, a_o, b_o, shamt_o, alu_operation_o, store_data_o,
           write_addr_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold handling
// and EX/MEM > MEM/WB operand forwarding on the registered source operands.
module id_ex_stage (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  write_addr;
    logic [3:0]  alu_operation;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } stage_t;

  stage_t stage_reg;
  stage_t stage_next;
  stage_t decode_in;
  logic   hazard;

  always_comb begin
    decode_in               = '0;
    decode_in.valid         = bus.valid_i;
    decode_in.rs_addr       = bus.rs_addr_i;
    decode_in.rt_addr       = bus.rt_addr_i;
    decode_in.rs_data       = bus.rs_data_i;
    decode_in.rt_data       = bus.rt_data_i;
    decode_in.imm           = bus.imm_i;
    decode_in.shamt         = bus.shamt_i;
    decode_in.write_addr    = bus.write_addr_i;
    decode_in.alu_operation = bus.alu_operation_i;
    decode_in.alu_src       = bus.alu_src_i;
    decode_in.reg_write     = bus.reg_write_i;
    decode_in.mem_read      = bus.mem_read_i;
    decode_in.mem_write     = bus.mem_write_i;
    decode_in.mem_to_reg    = bus.mem_to_reg_i;
  end

  // A load sitting in EX cannot forward to the instruction in decode that needs its result.
  assign hazard = stage_reg.mem_read && (stage_reg.write_addr != 5'd0) && bus.valid_i &&
                  ((stage_reg.write_addr == bus.rs_addr_i) ||
                   (stage_reg.write_addr == bus.rt_addr_i));

  // A flush takes precedence over the stall, so the decode instruction is dropped.
  assign bus.stall_o = hazard && !bus.flush_i;

  // A bubble is the all-zero stage word.
  always_comb begin
    stage_next = stage_reg;
    if (bus.flush_i) begin
      stage_next = '0;
    end else if (bus.hold_i) begin
      stage_next = stage_reg;
    end else if (hazard) begin
      stage_next = '0;
    end else begin
      stage_next = decode_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  // Element 0 is rs and element 1 is rt. Register 0 is never taken from a forward source.
  logic [4:0]  src_addr [2];
  logic [31:0] src_data [2];
  logic [31:0] fwd_data [2];

  assign src_addr[0] = stage_reg.rs_addr;
  assign src_addr[1] = stage_reg.rt_addr;
  assign src_data[0] = stage_reg.rs_data;
  assign src_data[1] = stage_reg.rt_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic ex_mem_hit;
      logic mem_wb_hit;

      assign ex_mem_hit = bus.ex_mem_reg_write_i && (bus.ex_mem_write_addr_i != 5'd0) &&
                          (bus.ex_mem_write_addr_i == src_addr[gi]);
      assign mem_wb_hit = bus.mem_wb_reg_write_i && (bus.mem_wb_write_addr_i != 5'd0) &&
                          (bus.mem_wb_write_addr_i == src_addr[gi]);
      assign fwd_data[gi] = ex_mem_hit ? bus.ex_mem_data_i :
                            mem_wb_hit ? bus.mem_wb_data_i : src_data[gi];
    end
  endgenerate

  assign bus.a_o             = fwd_data[0];
  assign bus.store_data_o    = fwd_data[1];
  assign bus.b_o             = stage_reg.alu_src ? stage_reg.imm : fwd_data[1];
  assign bus.valid_o         = stage_reg.valid;
  assign bus.shamt_o         = stage_reg.shamt;
  assign bus.alu_operation_o = stage_reg.alu_operation;
  assign bus.write_addr_o    = stage_reg.write_addr;
  assign bus.reg_write_o     = stage_reg.reg_write;
  assign bus.mem_read_o      = stage_reg.mem_read;
  assign bus.mem_write_o     = stage_reg.mem_write;
  assign bus.mem_to_reg_o    = stage_reg.mem_to_reg;

endmodule
